// File: rtl/ex_mem_stage_pkg.sv
// Shared definitions for the EX->MEM pipeline boundary: default widths and payload layout.
package ex_mem_stage_pkg;

   localparam int unsigned EX_MEM_DATA_W = 32;
   localparam int unsigned EX_MEM_REG_AW = 5;
   localparam int unsigned EX_MEM_CNT_W  = 32;

   // Field order here is the bit order used when the stage packs its payload vector.
   typedef struct packed {
      logic [EX_MEM_DATA_W-1:0] rslt;
      logic [EX_MEM_DATA_W-1:0] store_data;
      logic [EX_MEM_REG_AW-1:0] dest;
      logic                     reg_write;
      logic                     mem_read;
      logic                     mem_write;
      logic                     branch_taken;
   } ex_mem_payload_t;

   function automatic int unsigned payload_w(int unsigned data_w, int unsigned reg_aw);
      return 2 * data_w + reg_aw + 4;
   endfunction

endpackage

// File: rtl/ex_mem_stage_skid.sv
// Two-register valid/ready skid buffer; in_ready_o is purely registered state.
module skid_buffer #(
   parameter int unsigned W = 8
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         flush_i,
   input  logic         in_valid_i,
   output logic         in_ready_o,
   input  logic [W-1:0] in_data_i,
   output logic         out_valid_o,
   input  logic         out_ready_i,
   output logic [W-1:0] out_data_o
);

   logic         main_valid_q, main_valid_d;
   logic         skid_valid_q, skid_valid_d;
   logic [W-1:0] main_q, main_d;
   logic [W-1:0] skid_q, skid_d;
   logic         accept, emit;

   assign in_ready_o  = ~skid_valid_q;
   assign out_valid_o = main_valid_q;
   assign out_data_o  = main_q;
   assign accept      = in_valid_i & in_ready_o;
   assign emit        = main_valid_q & out_ready_i;

   always_comb begin
      main_valid_d = main_valid_q;
      skid_valid_d = skid_valid_q;
      main_d       = main_q;
      skid_d       = skid_q;
      if (flush_i) begin
         main_valid_d = 1'b0;
         skid_valid_d = 1'b0;
      end else if (!main_valid_q) begin
         if (accept) begin
            main_d       = in_data_i;
            main_valid_d = 1'b1;
         end
      end else if (emit) begin
         // skid is only occupied when main is, so it always drains first to keep FIFO order
         if (skid_valid_q) begin
            main_d       = skid_q;
            skid_valid_d = 1'b0;
         end else if (accept) begin
            main_d = in_data_i;
         end else begin
            main_valid_d = 1'b0;
         end
      end else if (accept) begin
         skid_d       = in_data_i;
         skid_valid_d = 1'b1;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         main_valid_q <= 1'b0;
         skid_valid_q <= 1'b0;
         main_q       <= '0;
         skid_q       <= '0;
      end else begin
         main_valid_q <= main_valid_d;
         skid_valid_q <= skid_valid_d;
         main_q       <= main_d;
         skid_q       <= skid_d;
      end
   end

endmodule

// File: rtl/ex_mem_stage.sv
// EX->MEM register boundary: packs ALU result and controls into a skid buffer, counts stall cycles.
module ex_mem_stage
   import ex_mem_stage_pkg::*;
#(
   parameter int unsigned DATA_W = EX_MEM_DATA_W,
   parameter int unsigned REG_AW = EX_MEM_REG_AW,
   parameter int unsigned CNT_W  = EX_MEM_CNT_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_rslt,
   input  logic              in_zero,
   input  logic [DATA_W-1:0] in_store_data,
   input  logic [REG_AW-1:0] in_dest,
   input  logic              in_reg_write,
   input  logic              in_mem_read,
   input  logic              in_mem_write,
   input  logic              in_branch,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_rslt,
   output logic [DATA_W-1:0] out_store_data,
   output logic [REG_AW-1:0] out_dest,
   output logic              out_reg_write,
   output logic              out_mem_read,
   output logic              out_mem_write,
   output logic              out_branch_taken,
   output logic [CNT_W-1:0]  stall_cycles
);

   localparam int unsigned PAY_W = payload_w(DATA_W, REG_AW);

   logic [PAY_W-1:0] in_pay, out_pay;
   logic [CNT_W-1:0] stall_q, stall_d;

   assign in_pay = {in_rslt, in_store_data, in_dest, in_reg_write,
                    in_mem_read, in_mem_write, in_branch & in_zero};

   skid_buffer #(.W(PAY_W)) u_skid (
      .clk_i       (clk),
      .rst_i       (rst),
      .flush_i     (flush),
      .in_valid_i  (in_valid),
      .in_ready_o  (in_ready),
      .in_data_i   (in_pay),
      .out_valid_o (out_valid),
      .out_ready_i (out_ready),
      .out_data_o  (out_pay)
   );

   assign {out_rslt, out_store_data, out_dest, out_reg_write,
           out_mem_read, out_mem_write, out_branch_taken} = out_pay;

   always_comb begin
      stall_d = stall_q;
      if (out_valid && !out_ready && (stall_q != '1))
         stall_d = stall_q + CNT_W'(1);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) stall_q <= '0;
      else     stall_q <= stall_d;
   end

   assign stall_cycles = stall_q;

endmodule

// File: doc/ex_mem_stage.md
Name: ex_mem_stage

Overview:
- Registered EX->MEM boundary directly downstream of the ALU.
- Captures the ALU result, the zero flag and the instruction's memory/writeback control bits; presents them to the data-memory stage.
- Uses a valid/ready handshake with a 2-entry skid buffer, so in_ready never depends combinationally on out_ready.
- Also provides flush for branch squash and a saturating stall-cycle counter for performance monitoring.

Parameters:
DATA_W, 32, width of ALU result and store data
REG_AW, 5, destination register index width
CNT_W, 32, stall counter width

Ports:
clk  input  1  single clock, rising edge
rst  input  1  asynchronous reset, active-high
flush  input  1  synchronous squash of all held entries
in_valid  input  1  upstream entry valid
in_ready  output  1  stage can accept this cycle
in_rslt  input  DATA_W  ALU result
in_zero  input  1  ALU zero flag
in_store_data  input  DATA_W  rt operand for stores
in_dest  input  REG_AW  writeback register index
in_reg_write  input  1  writeback enable
in_mem_read  input  1  load
in_mem_write  input  1  store
in_branch  input  1  instruction is a beq-type branch
out_valid  output  1  held entry valid
out_ready  input  1  downstream accepts
out_rslt  output  DATA_W  registered result (memory address or writeback value)
out_store_data  output  DATA_W  registered store data
out_dest  output  REG_AW  registered destination
out_reg_write, out_mem_read, out_mem_write  output  1 each  registered controls
out_branch_taken  output  1  in_branch AND in_zero, computed at capture
stall_cycles  output  CNT_W  cycles with out_valid=1 and out_ready=0

Behaviour:
- Reset (async, rst=1): main_valid=0, skid_valid=0, in_ready=1, out_valid=0, all payload outputs 0, stall_cycles=0. Takes effect immediately regardless of clk; an in-flight entry is lost.
- Handshake terms:
  - accept = in_valid & in_ready
  - emit = out_valid & out_ready
- in_ready is the registered value ~skid_valid; it has no combinational path from out_ready or in_valid.
- Storage: main register drives the out_* ports; skid register holds one overflow entry. Payload = {rslt, store_data, dest, reg_write, mem_read, mem_write, branch_taken}. branch_taken = in_branch & in_zero is formed on capture; in_zero is not stored otherwise.
- Next-state rules at each posedge, flush=0, in priority order:
  - main empty: if accept, main <- input.
  - main full and emit: if skid_valid, main <- skid and skid clears; else if accept, main <- input; else main_valid <- 0.
  - main full, no emit, accept: skid <- input, skid_valid <- 1.
- Simultaneous emit + accept with the skid full cannot occur, since in_ready=0.
- Ordering: strict FIFO. Latency from accept into an empty stage to out_valid=1 is 1 cycle.
- Full sustained throughput: one entry per cycle when out_ready=1 continuously.
- Payload registers hold their last value when invalid. Consumers qualify with out_valid; control outputs are not forced to 0.
- flush=1 (synchronous, highest priority):
  - main_valid and skid_valid both clear at the edge.
  - Any input presented that cycle is discarded even if accept=1.
  - in_ready=1 the next cycle.
  - An emit in the same cycle still counts as completed downstream.
- stall_cycles increments by 1 each cycle out_valid=1 and out_ready=0, and saturates at all-ones. Flush does not clear it; only rst does.
- Occupancy is 0..2. Overflow is impossible by construction. Verification asserts no accept while skid_valid=1.

Decomposition:
- Shared package: DATA_W/REG_AW defaults and a packed struct ex_mem_payload_t {rslt, store_data, dest, reg_write, mem_read, mem_write, branch_taken}.
- A sub-module skid_buffer, parameterised on payload width, holds the two-register valid/ready logic and is reusable for other stage boundaries.
- ex_mem_stage instantiates skid_buffer, packs the payload, forms branch_taken and owns the stall counter.

Test Plan:
- Reset mid-operation: rst pulsed asynchronously between edges while out_valid=1 -> out_valid=0, in_ready=1, out_rslt=0, stall_cycles=0 immediately.
- Pass-through: in_rslt=0x0000_0010, in_dest=5, in_reg_write=1, out_ready=1 -> next cycle out_valid=1, out_rslt=0x10, out_dest=5; stream of 8 back-to-back entries emerges in order, one per cycle.
- Backpressure: out_ready=0, push 0xA then 0xB:
  - in_ready drops to 0 after 0xB is accepted, 3rd offer not accepted.
  - stall_cycles counts each blocked cycle.
  - out_ready=1 -> 0xA then 0xB emitted and in_ready returns to 1.
- Branch flag: in_branch=1 with in_zero=1 -> out_branch_taken=1; in_zero=0 -> 0; in_branch=0 with in_zero=1 -> 0.
- Flush: stage holding two entries, flush=1 with in_valid=1 (0xC) -> next cycle out_valid=0, in_ready=1, 0xC never appears.
- Counter saturation: CNT_W=4, hold out_valid=1 and out_ready=0 for 20 cycles -> stall_cycles sticks at 15.
